// File: rtl/vx_fifo_queue_mc.sv
// Multi-queue FIFO: NUM_QUEUES independent logical FIFOs of DEPTH entries each,
// sharing one RAM (synchronous write, asynchronous read).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_qid    write data_in to the tail of queue push_qid
//   data_in           push data
//   pop, pop_qid      remove the head of queue pop_qid
//   data_out          head of queue pop_qid (combinational, valid when non-empty)
//   flush             per-queue flush mask; overrides push/pop to that queue
//   empty, alm_empty  per-queue size == 0 / size <= ALM_EMPTY (registered)
//   full, alm_full    per-queue size == DEPTH / size >= ALM_FULL (registered)
//   size              per-queue occupancy, queue q at [q*SIZEW +: SIZEW]
module vx_fifo_queue_mc #(
  parameter int unsigned DATAW      = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NUM_QUEUES = 4,
  parameter int unsigned ALM_FULL   = DEPTH - 1,
  parameter int unsigned ALM_EMPTY  = 1,
  parameter int unsigned LUTRAM     = 1,
  parameter int unsigned QIDW       = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int unsigned SIZEW      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [QIDW-1:0]             push_qid,
  input  logic [DATAW-1:0]            data_in,
  input  logic                        pop,
  input  logic [QIDW-1:0]             pop_qid,
  output logic [DATAW-1:0]            data_out,
  input  logic [NUM_QUEUES-1:0]       flush,
  output logic [NUM_QUEUES-1:0]       empty,
  output logic [NUM_QUEUES-1:0]       alm_empty,
  output logic [NUM_QUEUES-1:0]       full,
  output logic [NUM_QUEUES-1:0]       alm_full,
  output logic [NUM_QUEUES*SIZEW-1:0] size
);

  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned WORDS = NUM_QUEUES * DEPTH;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [PTRW-1:0]       wr_ptr_q [NUM_QUEUES];
  logic [PTRW-1:0]       wr_ptr_d [NUM_QUEUES];
  logic [PTRW-1:0]       rd_ptr_q [NUM_QUEUES];
  logic [PTRW-1:0]       rd_ptr_d [NUM_QUEUES];
  logic [SIZEW-1:0]      size_q   [NUM_QUEUES];
  logic [SIZEW-1:0]      size_d   [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] empty_q, empty_d, alm_empty_q, alm_empty_d;
  logic [NUM_QUEUES-1:0] full_q, full_d, alm_full_q, alm_full_d;
  logic [NUM_QUEUES-1:0] push_sel, push_ok, pop_ok;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      push_sel[q] = push && (push_qid == QIDW'(q)) && !flush[q];
      pop_ok[q]   = pop && (pop_qid == QIDW'(q)) && !flush[q] && (size_q[q] != '0);
      // A full queue accepts a push only when it is popped in the same cycle.
      push_ok[q]  = push_sel[q] && ((size_q[q] != SIZEW'(DEPTH)) || pop_ok[q]);
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      size_d[q]   = size_q[q];
      if (flush[q]) begin
        wr_ptr_d[q] = '0;
        rd_ptr_d[q] = '0;
        size_d[q]   = '0;
      end else begin
        if (push_ok[q]) wr_ptr_d[q] = ptr_inc(wr_ptr_q[q]);
        if (pop_ok[q])  rd_ptr_d[q] = ptr_inc(rd_ptr_q[q]);
        if (push_ok[q] && !pop_ok[q])      size_d[q] = size_q[q] + 1'b1;
        else if (pop_ok[q] && !push_ok[q]) size_d[q] = size_q[q] - 1'b1;
      end
      empty_d[q]     = (size_d[q] == '0);
      alm_empty_d[q] = (size_d[q] <= SIZEW'(ALM_EMPTY));
      full_d[q]      = (size_d[q] == SIZEW'(DEPTH));
      alm_full_d[q]  = (size_d[q] >= SIZEW'(ALM_FULL));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        size_q[q]   <= '0;
      end
      empty_q     <= '1;
      alm_empty_q <= '1;
      full_q      <= '0;
      alm_full_q  <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        size_q[q]   <= size_d[q];
      end
      empty_q     <= empty_d;
      alm_empty_q <= alm_empty_d;
      full_q      <= full_d;
      alm_full_q  <= alm_full_d;
    end
  end

  logic          we;
  logic [AW-1:0] wr_addr, rd_addr;

  assign we      = |push_ok;
  assign wr_addr = AW'(push_qid) * AW'(DEPTH) + AW'(wr_ptr_q[push_qid]);
  assign rd_addr = AW'(pop_qid) * AW'(DEPTH) + AW'(rd_ptr_q[pop_qid]);

  if (LUTRAM != 0) begin : g_lutram
    (* ram_style = "distributed" *) logic [DATAW-1:0] mem [WORDS];
    always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= data_in;
    end
    assign data_out = mem[rd_addr];
  end else begin : g_ram
    (* ram_style = "block" *) logic [DATAW-1:0] mem [WORDS];
    always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= data_in;
    end
    assign data_out = mem[rd_addr];
  end

  assign empty     = empty_q;
  assign alm_empty = alm_empty_q;
  assign full      = full_q;
  assign alm_full  = alm_full_q;

  always_comb begin
    size = '0;
    for (int q = 0; q < NUM_QUEUES; q++) size[q*SIZEW +: SIZEW] = size_q[q];
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !flush[push_qid] && full_q[push_qid]
                && !(pop && (pop_qid == push_qid))))
        else $warning("vx_fifo_queue_mc: push to full queue %0d ignored", push_qid);
      assert (!(pop && !flush[pop_qid] && empty_q[pop_qid]))
        else $warning("vx_fifo_queue_mc: pop from empty queue %0d ignored", pop_qid);
    end
  end
`endif

endmodule

// File: tb/tb_vx_fifo_queue_mc.sv
module tb_vx_fifo_queue_mc;
  localparam int unsigned DATAW = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned NQ    = 4;
  localparam int unsigned QIDW  = 2;
  localparam int unsigned SIZEW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push = 1'b0;
  logic [QIDW-1:0]  push_qid = '0;
  logic [DATAW-1:0] data_in = '0;
  logic             pop = 1'b0;
  logic [QIDW-1:0]  pop_qid = '0;
  logic [DATAW-1:0] data_out;
  logic [NQ-1:0]    flush = '0;
  logic [NQ-1:0]    empty, alm_empty, full, alm_full;
  logic [NQ*SIZEW-1:0] size;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATAW-1:0] sb [NQ][$];
  logic [DATAW-1:0] exp_d;

  vx_fifo_queue_mc #(
    .DATAW(DATAW), .DEPTH(DEPTH), .NUM_QUEUES(NQ), .ALM_FULL(DEPTH - 1), .ALM_EMPTY(1),
    .LUTRAM(1), .QIDW(QIDW), .SIZEW(SIZEW)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .push_qid(push_qid), .data_in(data_in),
    .pop(pop), .pop_qid(pop_qid), .data_out(data_out), .flush(flush), .empty(empty),
    .alm_empty(alm_empty), .full(full), .alm_full(alm_full), .size(size)
  );

  always #5 clk = ~clk;

  function automatic logic [NQ*SIZEW-1:0] exp_size();
    logic [NQ*SIZEW-1:0] v = '0;
    for (int q = 0; q < NQ; q++) v[q*SIZEW +: SIZEW] = SIZEW'(sb[q].size());
    return v;
  endfunction

  // kind: 0 empty, 1 alm_empty, 2 full, 3 alm_full
  function automatic logic [NQ-1:0] exp_flag(input int kind);
    logic [NQ-1:0] v = '0;
    for (int q = 0; q < NQ; q++) begin
      int sz = sb[q].size();
      case (kind)
        0: v[q] = (sz == 0);
        1: v[q] = (sz <= 1);
        2: v[q] = (sz == DEPTH);
        default: v[q] = (sz >= DEPTH - 1);
      endcase
    end
    return v;
  endfunction

  task automatic drive(input logic ps, input int pq, input logic [DATAW-1:0] d,
                       input logic pp, input int oq, input logic [NQ-1:0] fl);
    push = ps; push_qid = QIDW'(pq); data_in = d;
    pop = pp; pop_qid = QIDW'(oq); flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL reset_empty got %h want f", empty); end
    n_cmp++; if (alm_empty !== 4'hF) begin n_err++; $display("FAIL reset_alm_empty got %h want f", alm_empty); end
    n_cmp++; if (full !== 4'h0) begin n_err++; $display("FAIL reset_full got %h want 0", full); end
    n_cmp++; if (alm_full !== 4'h0) begin n_err++; $display("FAIL reset_alm_full got %h want 0", alm_full); end
    n_cmp++; if (size !== '0) begin n_err++; $display("FAIL reset_size got %h want 0", size); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2, DATAW'(8'hA1 + i), 1'b0, 2, '0);
      sb[2].push_back(DATAW'(8'hA1 + i));
      tick();
      if (i == 0) begin
        n_cmp++;
        if (empty !== exp_flag(0)) begin
          n_err++; $display("FAIL basic_first_empty got %h want %h", empty, exp_flag(0));
        end
      end
    end
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL basic_size got %h want %h", size, exp_size()); end
    n_cmp++; if (full !== exp_flag(2)) begin n_err++; $display("FAIL basic_full got %h want %h", full, exp_flag(2)); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, '0, 1'b1, 2, '0);
      #1;
      exp_d = sb[2].pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL basic_pop%0d got %h want %h", i, data_out, exp_d); end
      tick();
    end
    n_cmp++; if (empty !== exp_flag(0)) begin n_err++; $display("FAIL basic_drained got %h want %h", empty, exp_flag(0)); end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1, DATAW'(i), 1'b0, 1, '0);
      sb[1].push_back(DATAW'(i));
      tick();
    end
    n_cmp++; if (full !== exp_flag(2)) begin n_err++; $display("FAIL wrap_full got %h want %h", full, exp_flag(2)); end
    n_cmp++; if (alm_full !== exp_flag(3)) begin n_err++; $display("FAIL wrap_alm_full got %h want %h", alm_full, exp_flag(3)); end
    for (int k = 4; k < 14; k++) begin
      drive(1'b1, 1, DATAW'(k), 1'b1, 1, '0);
      #1;
      exp_d = sb[1].pop_front();
      sb[1].push_back(DATAW'(k));
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_data k=%0d got %h want %h", k, data_out, exp_d); end
      tick();
      n_cmp++;
      if (size !== exp_size() || full[1] !== 1'b1) begin
        n_err++; $display("FAIL wrap_size k=%0d got size %h full %h want size %h full[1]=1", k, size, full, exp_size());
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, '0, 1'b1, 1, '0);
      #1;
      exp_d = sb[1].pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL wrap_drain%0d got %h want %h", i, data_out, exp_d); end
      tick();
    end
  endtask

  task automatic test_interleave();
    drive(1'b1, 0, 8'h10, 1'b0, 3, '0); sb[0].push_back(8'h10); tick();
    drive(1'b1, 3, 8'h30, 1'b0, 0, '0); sb[3].push_back(8'h30); tick();
    drive(1'b1, 0, 8'h11, 1'b0, 3, '0); sb[0].push_back(8'h11); tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL inter_size got %h want %h", size, exp_size()); end
    for (int i = 0; i < 3; i++) begin
      int q = (i == 1) ? 3 : 0;
      drive(1'b0, 0, '0, 1'b1, q, '0);
      #1;
      exp_d = sb[q].pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL inter_pop q%0d got %h want %h", q, data_out, exp_d); end
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1, 8'h21, 1'b0, 0, '0); sb[1].push_back(8'h21); tick();
    drive(1'b1, 1, 8'h22, 1'b0, 0, '0); sb[1].push_back(8'h22); tick();
    drive(1'b1, 0, 8'h05, 1'b0, 0, '0); sb[0].push_back(8'h05); tick();
    drive(1'b1, 1, 8'h77, 1'b1, 0, 4'b0010);
    #1;
    exp_d = sb[0].pop_front();
    sb[1].delete();
    n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL flush_q0_pop got %h want %h", data_out, exp_d); end
    tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL flush_size got %h want %h", size, exp_size()); end
    n_cmp++; if (empty !== exp_flag(0)) begin n_err++; $display("FAIL flush_empty got %h want %h", empty, exp_flag(0)); end
    drive(1'b1, 1, 8'h88, 1'b0, 1, '0); sb[1].push_back(8'h88); tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL flush_repush_size got %h want %h", size, exp_size()); end
    drive(1'b0, 0, '0, 1'b1, 1, '0);
    #1;
    exp_d = sb[1].pop_front();
    n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL flush_repush_data got %h want %h", data_out, exp_d); end
    tick();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2, DATAW'(8'hB0 + i), 1'b0, 2, '0);
      sb[2].push_back(DATAW'(8'hB0 + i));
      tick();
    end
    drive(1'b1, 2, 8'hEE, 1'b0, 2, '0);
    tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL illegal_push_size got %h want %h", size, exp_size()); end
    n_cmp++; if (full !== exp_flag(2)) begin n_err++; $display("FAIL illegal_push_full got %h want %h", full, exp_flag(2)); end
    drive(1'b0, 0, '0, 1'b1, 3, '0);
    tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL illegal_pop_size got %h want %h", size, exp_size()); end
    n_cmp++; if (empty !== exp_flag(0)) begin n_err++; $display("FAIL illegal_pop_empty got %h want %h", empty, exp_flag(0)); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, '0, 1'b1, 2, '0);
      #1;
      exp_d = sb[2].pop_front();
      n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL illegal_drain%0d got %h want %h", i, data_out, exp_d); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 0, 8'h41, 1'b0, 0, '0); sb[0].push_back(8'h41); tick();
    drive(1'b1, 3, 8'h42, 1'b0, 0, '0); sb[3].push_back(8'h42); tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL arst_pre_size got %h want %h", size, exp_size()); end
    #3;
    reset = 1'b1;
    #1;
    for (int q = 0; q < NQ; q++) sb[q].delete();
    n_cmp++; if (empty !== 4'hF) begin n_err++; $display("FAIL arst_empty got %h want f", empty); end
    n_cmp++; if (alm_empty !== 4'hF) begin n_err++; $display("FAIL arst_alm_empty got %h want f", alm_empty); end
    n_cmp++; if (alm_full !== 4'h0) begin n_err++; $display("FAIL arst_alm_full got %h want 0", alm_full); end
    n_cmp++; if (size !== '0) begin n_err++; $display("FAIL arst_size got %h want 0", size); end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 0, 8'h55, 1'b0, 0, '0); sb[0].push_back(8'h55); tick();
    n_cmp++; if (size !== exp_size()) begin n_err++; $display("FAIL arst_post_size got %h want %h", size, exp_size()); end
    drive(1'b0, 0, '0, 1'b1, 0, '0);
    #1;
    exp_d = sb[0].pop_front();
    n_cmp++; if (data_out !== exp_d) begin n_err++; $display("FAIL arst_post_data got %h want %h", data_out, exp_d); end
    tick();
    n_cmp++; if (empty !== exp_flag(0)) begin n_err++; $display("FAIL arst_post_empty got %h want %h", empty, exp_flag(0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_interleave();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
